// File: rtl/spi_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_fifo
// Purpose  : 16-entry command/data queue between the CPU SPI registers and
//            the screen SPI shifter. Entries are drained one at a time using
//            the shifter start/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_fifo #(
    parameter int AW      = 4,
    parameter int BUSY_TO = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_c,
    input  logic          wr_d8,
    input  logic          wr_d16,
    input  logic [15:0]   wr_data,
    input  logic          clr_ovf,
    input  logic          spi_ready,
    output logic          spi_startC,
    output logic          spi_startD8,
    output logic          spi_startD16,
    output logic [15:0]   spi_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;
    localparam int TW    = (BUSY_TO > 1) ? $clog2(BUSY_TO + 1) : 1;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TO - 1);

    // Entry type codes stored in the upper two bits of each entry
    localparam logic [1:0] T_C   = 2'b01;
    localparam logic [1:0] T_D8  = 2'b10;
    localparam logic [1:0] T_D16 = 2'b11;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ISSUE      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY  = 2'd2;
    localparam logic [1:0] S_WAIT_READY = 2'd3;

    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   data_q;
    logic [1:0]    type_q;

    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic [1:0]    push_type;
    logic [17:0]   head;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign overflow = ovf_q;
    assign spi_data = data_q;
    assign head     = mem_q[rd_ptr_q];

    // Strobe priority C > D8 > D16; at most one entry written per cycle
    always_comb begin
        push_type = T_D16;
        if (wr_c)
            push_type = T_C;
        else if (wr_d8)
            push_type = T_D8;
    end

    assign push_req = wr_c | wr_d8 | wr_d16;
    // A push against a full queue is dropped even if a pop frees a slot this cycle
    assign push_ok  = push_req & ~full;
    assign pop      = (state_q == S_IDLE) & ~empty & spi_ready;

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {push_type, wr_data};
    end

    // Pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            // Setting wins over clearing when both happen together
            if (push_req && full)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    // Capture the popped payload; C/D8 payloads are zero-extended
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            type_q <= T_C;
        end else if (pop) begin
            type_q <= head[17:16];
            data_q <= (head[17:16] == T_D16) ? head[15:0] : {8'h00, head[7:0]};
        end
    end

    // FSM state and busy-timer register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // FSM next-state; the timer bounds how long we wait for the shifter to go busy
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (pop)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
                timer_d = '0;
            end
            S_WAIT_BUSY: begin
                if (!spi_ready)
                    state_d = S_WAIT_READY;
                else if (timer_q == TMR_LAST)
                    state_d = S_IDLE;
                else
                    timer_d = timer_q + TMR_ONE;
            end
            S_WAIT_READY: begin
                if (spi_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: a single start pulse, only while in ISSUE
    always_comb begin
        spi_startC   = 1'b0;
        spi_startD8  = 1'b0;
        spi_startD16 = 1'b0;
        if (state_q == S_ISSUE) begin
            case (type_q)
                T_C:     spi_startC   = 1'b1;
                T_D8:    spi_startD8  = 1'b1;
                T_D16:   spi_startD16 = 1'b1;
                default: spi_startC   = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire
